tone_gen: RTL and testbench
===========================

TONE_GEN -- requirements
Module: tone_gen

Interface
REQ-001 SHALL have parameter DIV, default 625, meaning clocks per audio sample (min 3).
REQ-002 SHALL have parameter PHASE_BITS, default 24, meaning phase accumulator width (min 16).
REQ-003 SHALL have parameter ATTACK_STEP, default 4, meaning envelope increment per sample (1..256).
REQ-004 SHALL have parameter RELEASE_STEP, default 1, meaning envelope decrement per sample (1..256).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port freq_i  input  PHASE_BITS  phase increment per sample.
REQ-008 SHALL have port wave_i  input  2  waveform: 0 square, 1 saw, 2 triangle, 3 silence.
REQ-009 SHALL have port gate_i  input  1  note on (1) / off (0).
REQ-010 SHALL have port audio_o  output  16  unsigned offset-binary sample; midscale 0x8000; feeds the 16-bit delta-sigma modulator input directly.
REQ-011 SHALL have port sample_o  output  1  one-clock strobe marking a new audio_o value.

Function
REQ-012 SHALL run counter cnt 0..DIV-1, wrapping to 0; tick = (cnt == DIV-1).
REQ-013 SHALL, on tick, update phase <= (phase + freq_i) mod 2^PHASE_BITS; freq_i is sampled only on tick.
REQ-014 SHALL use p = phase[PHASE_BITS-1:PHASE_BITS-16] as the waveform index.
REQ-015 SHALL form raw u: square = p[15] ? 0xFFFF : 0x0000; saw = p; triangle = p[15] ? ~{p[14:0],0} : {p[14:0],0}; silence = 0x8000.
REQ-016 SHALL compute audio = 0x8000 + ((u - 0x8000) signed * env) >>> 8, env 9-bit unsigned 0..256; env=256 reproduces u exactly; env=0 gives 0x8000; no overflow is possible.
REQ-017 SHALL implement envelope FSM states IDLE, ATTACK, SUSTAIN, RELEASE; FSM and env update only on tick, using gate_i sampled on that tick.
REQ-018 IDLE: env=0; gate=1 -> ATTACK.
REQ-019 ATTACK: env <= min(env+ATTACK_STEP, 256); on reaching 256 -> SUSTAIN; gate=0 -> RELEASE (no increment that tick).
REQ-020 SUSTAIN: env held 256; gate=0 -> RELEASE.
REQ-021 RELEASE: env <= max(env-RELEASE_STEP, 0); on reaching 0 -> IDLE; gate=1 -> ATTACK continuing from current env (no decrement that tick).
REQ-022 SHALL register audio_o and sample_o one clock after the tick-cycle update, computed from the updated phase/env: tick in cycle T -> sample_o=1 and new audio_o visible in cycle T+2; sample_o low otherwise.
REQ-023 audio_o SHALL hold its value between strobes; wave_i changes take effect at the next strobe only.
REQ-024 Phase wrap SHALL be silent modular wrap with no glitch or extra strobe.

Reset
REQ-025 rst=1 SHALL set cnt=0, phase=0, env=0, state IDLE, audio_o=0x8000, sample_o=0 on the next edge.
REQ-026 rst asserted mid-note or mid-pipeline SHALL discard any pending sample; first strobe after release occurs DIV+1 clocks after the first clock with rst=0.
REQ-027 rst SHALL take priority over every other update.

Configuration
REQ-028 Macro TONE_GEN_ENVELOPE_EN defined: FSM per REQ-017..021 compiled in.
REQ-029 Macro TONE_GEN_ENVELOPE_EN undefined: no FSM; on each tick env <= gate_i ? 256 : 0; ATTACK_STEP/RELEASE_STEP ignored; all other behaviour identical.

Verification
REQ-030 DIV=4, rst then release: sample_o pulses every 4 clocks, first pulse 5 clocks after release; audio_o=0x8000 while gate=0.
REQ-031 DIV=4, freq_i=0x010000, wave=saw, env forced 256 (macro off, gate=1): audio_o = 0x0100, 0x0200, 0x0300 ... wrapping 0xFF00 -> 0x0000.
REQ-032 Same freq, triangle: p=0x4000 -> 0x8000; p=0xC000 -> 0x7FFF; square p=0x8000 -> 0xFFFF, p=0x7F00 -> 0x0000.
REQ-033 Macro on, ATTACK_STEP=64, saw p=0xFFFF held (freq_i=0, phase preset by ramp): gate=1 -> env 64,128,192,256 over 4 strobes, then SUSTAIN; gate=0 with RELEASE_STEP=128 -> env 128,0, IDLE, audio_o=0x8000.
REQ-034 Macro on: gate drop at env=128 in ATTACK -> RELEASE; gate rise at env=64 in RELEASE -> ATTACK from 64 (next env 128 with step 64).
REQ-035 Assert rst for one clock mid-SUSTAIN: next cycle audio_o=0x8000, sample_o=0, env=0, state IDLE, phase=0.

Source files
------------

// File: rtl/tone_gen.sv
// tone_gen: phase-accumulator tone generator with envelope and offset-binary output.
//
// A free-running divider produces one tick every DIV clocks. On each tick the
// phase accumulator advances by freq_i and the envelope updates. One clock
// later the sample is shaped, scaled by the envelope and registered, so a tick
// in cycle T shows up as sample_o=1 and a new audio_o in cycle T+2.
//
// Ports
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   freq_i    phase increment per sample, sampled on tick only
//   wave_i    0 square, 1 saw, 2 triangle, 3 silence
//   gate_i    note on/off, sampled on tick only
//   audio_o   16-bit offset-binary sample, midscale 16'h8000
//   sample_o  one-clock strobe marking a new audio_o value
//
// Build option
//   TONE_GEN_ENVELOPE_EN  defined: attack/sustain/release envelope FSM.
//                         undefined: envelope jumps to 256/0 with gate_i.
//
// Envelope FSM (TONE_GEN_ENVELOPE_EN only)
//   state    | meaning
//   IDLE     | env held at 0, waiting for gate
//   ATTACK   | env ramps up by ATTACK_STEP per tick, capped at 256
//   SUSTAIN  | env held at 256 while gate stays high
//   RELEASE  | env ramps down by RELEASE_STEP per tick, floored at 0

module tone_gen #(
  parameter int DIV          = 625,
  parameter int PHASE_BITS   = 24,
  parameter int ATTACK_STEP  = 4,
  parameter int RELEASE_STEP = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PHASE_BITS-1:0] freq_i,
  input  logic [1:0]            wave_i,
  input  logic                  gate_i,
  output logic [15:0]           audio_o,
  output logic                  sample_o
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic [8:0]            env_q, env_d;
  logic                  tick;
  logic                  tick_q;
  logic [15:0]           audio_q, audio_d;
  logic                  sample_q;

  assign tick  = (cnt_q == CNT_MAX);
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  // Modular add: phase wrap is silent by construction.
  assign phase_d = tick ? phase_q + freq_i : phase_q;

`ifdef TONE_GEN_ENVELOPE_EN
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ATTACK  = 2'd1;
  localparam logic [1:0] ST_SUSTAIN = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [1:0] state_q, state_d;
  logic [9:0] env_sum;
  logic       attack_full;
  logic [8:0] env_inc;
  logic       release_empty;
  logic [8:0] env_dec;

  assign env_sum       = {1'b0, env_q} + 10'(ATTACK_STEP);
  assign attack_full   = (env_sum >= 10'd256);
  assign env_inc       = attack_full ? 9'd256 : env_sum[8:0];
  assign release_empty = (env_q <= 9'(RELEASE_STEP));
  assign env_dec       = release_empty ? 9'd0 : env_q - 9'(RELEASE_STEP);

  // A state change on a gate edge takes the whole tick: the target state's
  // ramp starts on the following tick, from the env value held here.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          env_d = 9'd0;
          if (gate_i) state_d = ST_ATTACK;
        end
        ST_ATTACK: begin
          if (!gate_i) begin
            state_d = ST_RELEASE;
          end else begin
            env_d = env_inc;
            if (attack_full) state_d = ST_SUSTAIN;
          end
        end
        ST_SUSTAIN: begin
          env_d = 9'd256;
          if (!gate_i) state_d = ST_RELEASE;
        end
        ST_RELEASE: begin
          if (gate_i) begin
            state_d = ST_ATTACK;
          end else begin
            env_d = env_dec;
            if (release_empty) state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          env_d   = 9'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end
`else
  always_comb begin
    env_d = env_q;
    if (tick) env_d = gate_i ? 9'd256 : 9'd0;
  end
`endif

  // Sample shaping, evaluated in the cycle after the tick so it sees the
  // freshly updated phase and env.
  logic [15:0]        p;
  logic [15:0]        u;
  logic signed [16:0] diff;
  logic signed [9:0]  env_s;
  logic signed [26:0] prod;

  assign p = phase_q[PHASE_BITS-1 -: 16];

  always_comb begin
    case (wave_i)
      2'd0:    u = p[15] ? 16'hFFFF : 16'h0000;
      2'd1:    u = p;
      2'd2:    u = p[15] ? ~{p[14:0], 1'b0} : {p[14:0], 1'b0};
      default: u = 16'h8000;
    endcase
  end

  // Signed deviation from midscale times env (0..256), then /256. With
  // env=256 the shift undoes the multiply exactly; the result always fits
  // back into 16 bits around midscale.
  assign diff    = $signed({1'b0, u}) - 17'sd32768;
  assign env_s   = {1'b0, env_q};
  assign prod    = 27'(diff) * 27'(env_s);
  assign audio_d = 16'h8000 + 16'(prod >>> 8);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      phase_q  <= '0;
      env_q    <= 9'd0;
      tick_q   <= 1'b0;
      audio_q  <= 16'h8000;
      sample_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      env_q    <= env_d;
      tick_q   <= tick;
      sample_q <= tick_q;
      if (tick_q) audio_q <= audio_d;
    end
  end

  assign audio_o  = audio_q;
  assign sample_o = sample_q;

endmodule

// File: tb/tb_tone_gen.sv
module tb_tone_gen;

  localparam int DIV = 4;
  localparam int PB  = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PB-1:0] freq = '0;
  logic [1:0]    wave = 2'd1;
  logic          gate = 1'b0;
  logic [15:0]   audio;
  logic          sample;

  int n_checks = 0;
  int n_pass   = 0;

  tone_gen #(
    .DIV(DIV), .PHASE_BITS(PB), .ATTACK_STEP(64), .RELEASE_STEP(128)
  ) dut (
    .clk(clk), .rst(rst), .freq_i(freq), .wave_i(wave), .gate_i(gate),
    .audio_o(audio), .sample_o(sample)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advances at least one clock, then up to a bounded number more, until a strobe.
  task automatic wait_strobe(input string tag);
    int k;
    step(1);
    k = 1;
    while (sample !== 1'b1 && k < 16) begin
      step(1);
      k++;
    end
    if (sample !== 1'b1) check({tag, " strobe timeout"}, 32'(sample), 1);
  endtask

  task automatic strobe_check(input string tag, input logic [15:0] exp);
    wait_strobe(tag);
    check(tag, audio, exp);
  endtask

  task automatic play(input string tag, input logic g, input logic [15:0] exp[$]);
    gate = g;
    foreach (exp[i]) strobe_check(tag, exp[i]);
  endtask

  // One-clock reset landing on a tick cycle, so a sample is in flight.
  task automatic reset_mid(input logic [15:0] exp_first);
    wait_strobe("pre-reset");
    step(2);
    check("tick before reset", 32'(dut.cnt_q), DIV - 1);
    rst = 1'b1;
    step(1);
    check("rst audio", audio, 16'h8000);
    check("rst sample", sample, 0);
    check("rst phase", dut.phase_q, 0);
    check("rst env", dut.env_q, 0);
`ifdef TONE_GEN_ENVELOPE_EN
    check("rst state", dut.state_q, 0);
`endif
    rst = 1'b0;
    for (int i = 1; i <= DIV; i++) begin
      step(1);
      check("no strobe after rst", sample, 0);
    end
    step(1);
    check("first strobe after rst", sample, 1);
    check("first audio after rst", audio, exp_first);
  endtask

  initial begin
    logic [15:0] q[$];

    step(2);
    check("reset audio", audio, 16'h8000);
    check("reset sample", sample, 0);
    check("reset phase", dut.phase_q, 0);
    check("reset env", dut.env_q, 0);

    rst = 1'b0;
    for (int i = 1; i <= DIV; i++) begin
      step(1);
      check("no early strobe", sample, 0);
    end
    step(1);
    check("first strobe", sample, 1);
    check("gate off audio", audio, 16'h8000);
    for (int s = 0; s < 2; s++) begin
      for (int i = 1; i < DIV; i++) begin
        step(1);
        check("strobe low", sample, 0);
      end
      step(1);
      check("strobe period", sample, 1);
      check("gate off audio", audio, 16'h8000);
    end

`ifndef TONE_GEN_ENVELOPE_EN
    // Saw ramp with full envelope, including wrap 0xFF00 -> 0x0000.
    rst = 1'b1; freq = 24'h010000; wave = 2'd1; gate = 1'b1;
    step(1);
    rst = 1'b0;
    for (int k = 1; k <= 257; k++) strobe_check("saw", 16'(k * 256));

    // Triangle.
    rst = 1'b1; wave = 2'd2;
    step(1);
    rst = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      wait_strobe("tri");
      if (k == 'h20) check("tri p=2000", audio, 16'h4000);
      if (k == 'h40) check("tri p=4000", audio, 16'h8000);
      if (k == 'h80) check("tri p=8000", audio, 16'hFFFF);
      if (k == 'hC0) check("tri p=C000", audio, 16'h7FFF);
    end

    // Square, then hold across a mid-interval wave change.
    rst = 1'b1; wave = 2'd0;
    step(1);
    rst = 1'b0;
    for (int k = 1; k <= 'h80; k++) begin
      wait_strobe("sq");
      if (k == 'h7F) check("sq p=7F00", audio, 16'h0000);
      if (k == 'h80) check("sq p=8000", audio, 16'hFFFF);
    end
    wave = 2'd3;
    for (int i = 1; i < DIV; i++) begin
      step(1);
      check("hold between strobes", audio, 16'hFFFF);
    end
    strobe_check("silence", 16'h8000);
    wave = 2'd1;
    strobe_check("saw p=8200", 16'h8200);
    gate = 1'b0;
    strobe_check("gate off", 16'h8000);
    gate = 1'b1;
    strobe_check("saw p=8400", 16'h8400);

    reset_mid(16'h0100);
`else
    // Preset phase to 0xFFFF00 with one tick, then freeze it.
    rst = 1'b1; freq = 24'hFFFF00; wave = 2'd1; gate = 1'b0;
    step(1);
    rst = 1'b0;
    strobe_check("preset", 16'h8000);
    freq = '0;
    strobe_check("preset hold", 16'h8000);
    check("preset phase", dut.phase_q, 24'hFFFF00);

    q = '{16'h8000, 16'h9FFF, 16'hBFFF, 16'hDFFF, 16'hFFFF, 16'hFFFF};
    play("attack", 1'b1, q);
    check("sustain state", dut.state_q, 2);
    q = '{16'hFFFF, 16'hBFFF, 16'h8000, 16'h8000};
    play("release", 1'b0, q);
    check("idle state", dut.state_q, 0);
    check("idle env", dut.env_q, 0);

    q = '{16'h8000, 16'h9FFF, 16'hBFFF};
    play("attack2", 1'b1, q);
    q = '{16'hBFFF, 16'h8000};
    play("drop in attack", 1'b0, q);

    q = '{16'h8000, 16'h9FFF, 16'hBFFF, 16'hDFFF};
    play("attack3", 1'b1, q);
    q = '{16'hDFFF, 16'h9FFF};
    play("release3", 1'b0, q);
    check("release env 64", dut.env_q, 64);
    q = '{16'h9FFF, 16'hBFFF};
    play("re-attack", 1'b1, q);
    check("re-attack env", dut.env_q, 128);

    reset_mid(16'h8000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
